// File: rtl/tx_packet_builder.sv
// Serialises a snapshot of the local node state into one 16-bit word stream.
// Define TX_CHECKSUM_EN to append an XOR checksum word to every packet.
module tx_packet_builder #(
    parameter logic [15:0] NODE_ID   = 16'h000C,
    parameter logic [3:0]  SYNC      = 4'hA,
    parameter int          STALL_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_req,
    input  logic [1:0]  tx_type,
    input  logic [15:0] hops,
    input  logic [15:0] q_value,
    input  logic [15:0] energy,
    input  logic [15:0] dest_id,
    input  logic [15:0] payload,
    input  logic        role,
    input  logic        low_e,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_abort
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [15:0] STALL_LIM = 16'(STALL_MAX);
    localparam bit          STALL_EN  = (STALL_MAX != 0);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] words_q [8];
    logic [15:0] cap     [8];
    logic [3:0]  cap_len;
    logic [2:0]  last_q;
    logic [2:0]  idx_q;
    logic [3:0]  seq_q;
    logic [15:0] stall_q;
    logic        done_q;
    logic        done_d;
    logic        abort_q;
    logic        abort_d;
    logic        hs;
    logic        stalled;
    logic        last_hs;
    logic        timeout;
    logic        start;
`ifdef TX_CHECKSUM_EN
    logic [15:0] csum;
`endif

    // Packet image assembled from the live inputs; latched only on start.
    always_comb begin
        cap = '{default: 16'h0000};
`ifdef TX_CHECKSUM_EN
        cap_len = (tx_type == 2'd0) ? 4'd6 : 4'd5;
`else
        cap_len = (tx_type == 2'd0) ? 4'd5 : 4'd4;
`endif
        cap[0] = {SYNC, tx_type, role, low_e, cap_len, seq_q};
        cap[1] = NODE_ID;
        unique case (tx_type)
            2'd0: begin
                cap[2] = hops;
                cap[3] = q_value;
                cap[4] = energy;
            end
            2'd1: begin
                cap[2] = q_value;
                cap[3] = energy;
            end
            2'd2: begin
                cap[2] = dest_id;
                cap[3] = q_value;
            end
            default: begin
                cap[2] = dest_id;
                cap[3] = payload;
            end
        endcase
`ifdef TX_CHECKSUM_EN
        csum = cap[0] ^ cap[1] ^ cap[2] ^ cap[3] ^ cap[4];
        if (tx_type == 2'd0) begin
            cap[5] = csum;
        end else begin
            cap[4] = csum;
        end
`endif
    end

    assign tx_valid = (state_q == SEND);
    assign tx_busy  = (state_q == SEND);
    assign tx_data  = tx_valid ? words_q[idx_q] : 16'h0000;
    assign tx_last  = tx_valid && (idx_q == last_q);
    assign tx_done  = done_q;
    assign tx_abort = abort_q;

    assign hs      = tx_valid && tx_ready;
    assign stalled = tx_valid && !tx_ready;
    assign last_hs = hs && (idx_q == last_q);
    assign timeout = STALL_EN && stalled
                     && (stall_q + 16'd1 == STALL_LIM);
    assign start   = (state_q == IDLE) && tx_req;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_req) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (timeout) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            seq_q   <= 4'd0;
            idx_q   <= 3'd0;
            last_q  <= 3'd0;
            stall_q <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                words_q[i] <= 16'h0000;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            if (start) begin
                words_q <= cap;
                last_q  <= 3'(cap_len - 4'd1);
                idx_q   <= 3'd0;
                stall_q <= 16'd0;
            end else if (hs) begin
                idx_q   <= idx_q + 3'd1;
                stall_q <= 16'd0;
            end else if (stalled && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (last_hs) begin
                seq_q <= seq_q + 4'd1;
            end
        end
    end

endmodule
